// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    StBoot    = 2'd0,
    StRun     = 2'd1,
    StMemWait = 2'd2,
    StFlush   = 2'd3
  } pipe_state_e;

  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] X0_ADDR = '0;

  // True when the D instruction needs a value that the load in X has not produced yet.
  function automatic logic load_use(input logic [REG_ADDR_W-1:0] rs1,
                                    input logic [REG_ADDR_W-1:0] rs2,
                                    input logic                  use_rs1,
                                    input logic                  use_rs2,
                                    input logic [REG_ADDR_W-1:0] rd,
                                    input logic                  memread);
    return memread && (rd != X0_ADDR) &&
           ((use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd)));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         clr_ni,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!clr_ni) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: load-use stalls,
// taken-branch squashes, memory-wait freeze, perf counters and watchdog.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned BOOT_CYCLES  = 2,
  parameter int unsigned WAIT_TIMEOUT = 64
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [REG_ADDR_W-1:0] d_rs1_i,
  input  logic [REG_ADDR_W-1:0] d_rs2_i,
  input  logic                  d_use_rs1_i,
  input  logic                  d_use_rs2_i,
  input  logic [REG_ADDR_W-1:0] x_rd_i,
  input  logic                  x_memread_i,
  input  logic                  m_branch_taken_i,
  input  logic                  mem_busy_i,
  output logic                  pc_en_o,
  output logic                  fd_en_o,
  output logic                  dx_en_o,
  output logic                  xm_en_o,
  output logic                  mw_en_o,
  output logic                  fd_flush_o,
  output logic                  dx_flush_o,
  output logic                  xm_flush_o,
  output logic [1:0]            state_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o,
  output logic                  err_o
);

  localparam int unsigned BootW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES + 1) : 1;
  localparam int unsigned WaitW = $clog2(WAIT_TIMEOUT + 1);

  pipe_state_e state_q, state_d, cur_st;
  logic [BootW-1:0] boot_cnt_q, boot_cnt_d;
  logic [WaitW-1:0] wait_cnt;
  logic             lu, stall_inc, flush_inc, wait_inc, err_q, err_d;

  assign lu = load_use(d_rs1_i, d_rs2_i, d_use_rs1_i, d_use_rs2_i, x_rd_i, x_memread_i);

  // While reset is held the outputs already behave as BOOT.
  assign cur_st = reset_i ? state_q : StBoot;

  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    pc_en_o    = 1'b0;
    fd_en_o    = 1'b0;
    dx_en_o    = 1'b0;
    xm_en_o    = 1'b0;
    mw_en_o    = 1'b0;
    fd_flush_o = 1'b0;
    dx_flush_o = 1'b0;
    xm_flush_o = 1'b0;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    unique case (cur_st)
      StBoot: begin
        fd_flush_o = 1'b1;
        dx_flush_o = 1'b1;
        xm_flush_o = 1'b1;
        if (32'(boot_cnt_q) + 32'd1 >= BOOT_CYCLES) begin
          state_d = StRun;
        end else begin
          boot_cnt_d = boot_cnt_q + BootW'(1);
        end
      end
      StRun, StFlush: begin
        if (mem_busy_i) begin
          stall_inc = 1'b1;
          state_d   = StMemWait;
        end else if ((cur_st == StRun) && m_branch_taken_i) begin
          {pc_en_o, fd_en_o, dx_en_o, xm_en_o, mw_en_o} = '1;
          {fd_flush_o, dx_flush_o, xm_flush_o}          = '1;
          flush_inc = 1'b1;
          state_d   = StFlush;
        end else if ((cur_st == StRun) && lu) begin
          // Hold F and D, drop a bubble into X, let the load move on.
          dx_en_o    = 1'b1;
          xm_en_o    = 1'b1;
          mw_en_o    = 1'b1;
          dx_flush_o = 1'b1;
          stall_inc  = 1'b1;
        end else begin
          {pc_en_o, fd_en_o, dx_en_o, xm_en_o, mw_en_o} = '1;
          state_d = StRun;
        end
      end
      StMemWait: begin
        stall_inc = 1'b1;
        if (!mem_busy_i) begin
          state_d = StRun;
        end
      end
      default: state_d = StBoot;
    endcase
  end

  assign wait_inc = mem_busy_i && (cur_st != StBoot) && (wait_cnt != WaitW'(WAIT_TIMEOUT));
  assign err_d    = err_q | (wait_inc && (wait_cnt == WaitW'(WAIT_TIMEOUT - 1)));

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q    <= StBoot;
      boot_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      err_q      <= err_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i  (clk_i),
    .clr_ni (reset_i),
    .inc_i  (stall_inc),
    .cnt_o  (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i  (clk_i),
    .clr_ni (reset_i),
    .inc_i  (flush_inc),
    .cnt_o  (flush_cnt_o)
  );

  // Counts consecutive busy cycles; any ready cycle clears it.
  sat_counter #(.W(WaitW)) u_wait_cnt (
    .clk_i  (clk_i),
    .clr_ni (reset_i && mem_busy_i),
    .inc_i  (wait_inc),
    .cnt_o  (wait_cnt)
  );

  assign state_o = state_q;
  assign err_o   = err_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the 5-stage RISC-V pipeline (F, D, X, M, W).
- Replaces the externally driven ready tie-off with per-register enable and flush strobes for the PC and the FD/DX/XM/MW pipeline registers.
- Detects load-use hazards between D and X, squashes younger stages on a taken branch resolved in M, and freezes the pipe while data memory is busy.
- Keeps saturating stall/flush performance counters and a memory-wait watchdog.

## Interface
Parameters:
- CNT_W, 32, width of the performance counters
- BOOT_CYCLES, 2, cycles after reset release that the pipe is held in flush
- WAIT_TIMEOUT, 64, consecutive mem_busy_i cycles before err_o sets

Ports:
- clk_i  in  1  sole clock; all state updates on rising edge
- reset_i  in  1  synchronous, active-low reset
- d_rs1_i  in  5  D-stage rs1 address
- d_rs2_i  in  5  D-stage rs2 address
- d_use_rs1_i  in  1  D instruction reads rs1
- d_use_rs2_i  in  1  D instruction reads rs2
- x_rd_i  in  5  X-stage destination register
- x_memread_i  in  1  X-stage instruction is a load
- m_branch_taken_i  in  1  taken branch/jump resolved in M
- mem_busy_i  in  1  data memory not ready this cycle
- pc_en_o  out  1  PC update enable (drives fetch PCready)
- fd_en_o, dx_en_o, xm_en_o, mw_en_o  out  1 each  pipeline register load enables
- fd_flush_o, dx_flush_o, xm_flush_o  out  1 each  load a bubble (all control bits 0)
- state_o  out  2  current FSM state
- stall_cnt_o  out  CNT_W  cycles with pc_en_o=0 in RUN, MEM_WAIT or FLUSH
- flush_cnt_o  out  CNT_W  taken-branch flush events
- err_o  out  1  sticky watchdog error

## Operation
- FSM states (package enum): BOOT=0, RUN=1, MEM_WAIT=2, FLUSH=3.
- Outputs are combinational from the state and the current inputs, so a stall or flush takes effect in the same cycle it is detected. Counters, the boot counter, the wait counter and err_o are registered.
- Load-use hazard (lu) is true when all of the following hold:
  - x_memread_i=1 and x_rd_i≠0;
  - (d_use_rs1_i and d_rs1_i==x_rd_i) or (d_use_rs2_i and d_rs2_i==x_rd_i).
- BOOT:
  - All enables 0; fd/dx/xm_flush_o=1.
  - Leaves for RUN after BOOT_CYCLES cycles with reset_i=1.
- RUN. Conditions are checked in priority order:
  1. mem_busy_i: all enables 0, no flush; go to MEM_WAIT.
  2. m_branch_taken_i: all enables 1 and fd/dx/xm_flush_o=1; flush_cnt increments; go to FLUSH.
  3. lu: pc_en_o=0, fd_en_o=0, dx_flush_o=1, xm_en_o=mw_en_o=1; stay in RUN.
  4. Otherwise: all enables 1, no flush.
- MEM_WAIT:
  - All enables 0; the wait counter increments.
  - On mem_busy_i=0: the wait counter clears and the state returns to RUN.
  - A branch or lu pending at that point is evaluated in the next RUN cycle. The frozen XM register still holds the branch.
- FLUSH:
  - Lasts exactly one cycle. lu is masked because D holds a bubble.
  - mem_busy_i behaves as in RUN. Otherwise all enables 1 and the state returns to RUN.
- Counters saturate at 2^CNT_W−1 and never wrap.
- err_o sets when the wait counter reaches WAIT_TIMEOUT. It clears only on reset.
- Register x0 never creates a hazard.

## Timing
- Reset values: state BOOT, boot/wait counters 0, stall_cnt_o=0, flush_cnt_o=0, err_o=0.
- Outputs during reset follow BOOT: enables 0, flushes 1.
- Load-use costs exactly 1 bubble cycle. The load reaches M the next cycle, lu drops, and D proceeds.
- A taken branch costs 3 squashed instructions (F, D, X) and 1 FLUSH cycle.
- Simultaneous events:
  - mem_busy_i beats a branch, which beats lu.
  - A branch together with lu: only the flush happens, with no extra stall.
- Reset asserted mid-operation: the next edge enters BOOT and clears all counters and err_o regardless of the current state.
- The wait counter saturates at WAIT_TIMEOUT.

## Structure
- Package pipe_ctrl_pkg: state enum pipe_state_e (2-bit), REG_ADDR_W=5, localparam X0_ADDR=0.
- Sub-module sat_counter (parameter W; inputs inc_i and a synchronous active-low clear), used for stall_cnt, flush_cnt and the wait counter.
- Hazard compare is a function in the package; next-state and output logic live in one always_comb block.

## Test plan
- Reset, then release with BOOT_CYCLES=2:
  - 2 cycles with pc_en_o=0 and flushes=1;
  - state_o=1 on cycle 3;
  - counters read 0.
- Load-use: x_memread_i=1, x_rd_i=5, d_rs2_i=5, d_use_rs2_i=1:
  - same cycle: pc_en_o=0, fd_en_o=0, dx_flush_o=1, xm_en_o=1;
  - stall_cnt_o=1 afterwards.
  - Repeat with x_rd_i=0: no stall.
- Taken branch in RUN with concurrent lu:
  - fd/dx/xm_flush_o=1 and pc_en_o=1;
  - state FLUSH for one cycle;
  - flush_cnt_o=1, stall_cnt_o unchanged.
- mem_busy_i high for 3 cycles while m_branch_taken_i=1:
  - all enables 0 and no flush for 3 cycles;
  - the flush fires on the first RUN cycle after busy drops.
- mem_busy_i held for 64 cycles:
  - err_o=1 on the 64th cycle and stays high after busy drops;
  - reset_i=0 clears err_o.
- Preload stall_cnt to 2^CNT_W−1 (CNT_W=4), force lu: stall_cnt_o stays 15.
